hms_timekeeper: RTL and testbench
=================================

# hms_timekeeper

Parametrised hours/minutes/seconds timekeeping core, the successor to the fixed 24-hour up-counting time block. It adds a configurable clock rate and hour modulus, a countdown-timer function with an expiry flag, wrap-free borrow logic, and a per-second strobe. It sits between the button-control block (which supplies `mode`, `plus`, `minus`) and the HMS display and flash blocks, which consume `hours`, `mins`, `secs`, `sec_tick` and `expired`.

## Interface

Parameters:
- `CLK_HZ`, default 50_000_000: `clk` cycles per second. Must be ≥ 2.
- `HOURS_MOD`, default 24: hour field counts 0..HOURS_MOD-1. Legal range 2..60.

Ports:
- `clk` — in, 1: single clock. All logic is on the rising edge.
- `reset` — in, 1: synchronous, active-high. Has priority over every other input.
- `enable` — in, 1: allows timekeeping while in run mode.
- `mode` — in, 2: 00 = run, 01 = adjust secs, 10 = adjust mins, 11 = adjust hours.
- `func` — in, 1: 0 = clock (count up), 1 = countdown.
- `plus` — in, 1: single-cycle increment pulse for the selected field.
- `minus` — in, 1: single-cycle decrement pulse for the selected field.
- `hours` — out, 6: current hours.
- `mins` — out, 6: current minutes.
- `secs` — out, 6: current seconds.
- `sec_tick` — out, 1: one-cycle pulse on each timed field update.
- `expired` — out, 1: level; countdown reached zero.

## Operation

- **Reset.** `hours`, `mins`, `secs`, the prescaler, `sec_tick` and `expired` all become 0.
- **Prescaler.** Width `$clog2(CLK_HZ)`. Counts 0..CLK_HZ-1 only while `enable` = 1 and `mode` = 00.
  - Holds its value while `enable` = 0.
  - Is cleared to 0 on every cycle where `mode` ≠ 00.
  - The count value CLK_HZ-1 is the "tick" cycle.
- **Clock function (func = 0), on tick:**
  - `secs` increments; 59 → 0 carries into `mins`.
  - `mins` 59 → 0 carries into `hours`.
  - `hours` HOURS_MOD-1 → 0.
- **Countdown function (func = 1), on tick:**
  - `secs` decrements; 0 → 59 borrows from `mins`.
  - `mins` 0 → 59 borrows from `hours`.
  - At 00:00:00 there is no decrement and no wrap; the value holds.
  - `expired` is set on the edge where the value becomes 00:00:00, or on any tick at which the value is already 00:00:00.
- **`expired` clearing.** Cleared by `reset`, by any accepted `plus`/`minus`, or by `func` = 0. Setting a field to zero by adjustment does not set `expired`.
- **Adjust modes (`mode` ≠ 00):**
  - No timed updates occur.
  - `plus` or `minus` changes only the selected field by ±1, modulo 60/60/HOURS_MOD, with wrap and no carry or borrow into neighbouring fields.
  - `plus` and `minus` asserted in the same cycle: no change, and `expired` is not cleared.
  - `plus`/`minus` are ignored in run mode.
- **`sec_tick`.** Asserted only on ticks. It is asserted on a countdown tick even when the value is held at zero.

## Timing

- All outputs are registered. A field update and its `sec_tick` are visible together after the tick edge.
- Latency from reset release, with `enable` = 1 and `mode` = 00:
  - first `sec_tick`/field update after exactly CLK_HZ edges;
  - thereafter, one update every CLK_HZ cycles.
- Latency of an adjust pulse: 1 cycle (the field changes on the edge that samples `plus`/`minus`).
- Switching `mode` from non-zero back to 00: the first tick follows CLK_HZ cycles later.
- Toggling `func` mid-second: the prescaler continues; the next tick uses the new direction.
- Reset asserted mid-second or mid-adjust: all outputs read 0 after that edge; no tick is emitted on that edge.

## Structure

- **Shared package `hms_pkg`:**
  - `mode` encodings: `MODE_RUN`, `MODE_SECS`, `MODE_MINS`, `MODE_HOURS`.
  - `func` encodings: `FUNC_CLOCK`, `FUNC_COUNTDOWN`.
  - `FIELD_W` = 6.
  - `SEC_MOD` = 60 and `MIN_MOD` = 60.
- **Sub-module `mod_counter`:**
  - Parameter `MOD`.
  - Inputs: `inc`, `dec`, `wrap_en`.
  - Outputs: `value`, `carry` (on MOD-1 → 0), `borrow` (on 0 → MOD-1).
  - Instantiated three times (secs, mins, hours), chained by carry/borrow for timed updates.
  - `wrap_en` is high during adjust and low for the countdown floor.
- **In `hms_timekeeper` itself:** the prescaler, the zero detect and the `expired` register.

## Test plan

Run with `CLK_HZ` = 4 and `HOURS_MOD` = 24 unless noted.

1. **Up-count.** Reset, `enable` = 1, `mode` = 00, `func` = 0, run 240 cycles → reads 00:01:00; exactly 60 `sec_tick` pulses, spaced 4 cycles apart.
2. **Rollover.** Adjust to 23:59:59, return to run, wait 4 cycles → 00:00:00 with `sec_tick` = 1. With `HOURS_MOD` = 12, 11:59:59 → 00:00:00.
3. **Adjust.**
   - `mode` = 01, one `minus` from 0 → `secs` = 59 and `mins` unchanged.
   - `mode` = 11, 25 `plus` pulses → `hours` = 1.
   - `plus` and `minus` together → no change.
   - No `sec_tick` at any point in adjust mode.
4. **Countdown.**
   - Set 00:00:02, `func` = 1, run: after 4 cycles 00:00:01; after 8 cycles 00:00:00 with `expired` = 1.
   - Another 20 cycles: the value holds and `expired` stays 1.
   - `mode` = 01 plus one `plus` → `secs` = 1 and `expired` = 0.
5. **Borrow.** Countdown from 01:00:00, one tick → 00:59:59.
6. **Hold and reset.**
   - `enable` = 0 for 10 cycles mid-second → the prescaler holds and the next tick is delayed by 10 cycles.
   - `reset` pulsed at 05:06:07 mid-second → all outputs 0 on the next edge.

Source files
------------

// File: rtl/hms_pkg.sv
// Shared encodings and field constants for the HMS timekeeping blocks.
package hms_pkg;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'b00,
      MODE_SECS  = 2'b01,
      MODE_MINS  = 2'b10,
      MODE_HOURS = 2'b11
   } mode_e;

   typedef enum logic {
      FUNC_CLOCK     = 1'b0,
      FUNC_COUNTDOWN = 1'b1
   } func_e;

   localparam int FIELD_W = 6;
   localparam int SEC_MOD = 60;
   localparam int MIN_MOD = 60;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up/down field counter with combinational carry/borrow out.
module mod_counter
   import hms_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   input  logic               dec,
   input  logic               wrap_en,
   output logic [FIELD_W-1:0] value,
   output logic               carry,
   output logic               borrow
);

   localparam logic [FIELD_W-1:0] TOP = FIELD_W'(MOD - 1);
   localparam logic [FIELD_W-1:0] ONE = FIELD_W'(1);

   logic [FIELD_W-1:0] value_q;
   logic [FIELD_W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      carry   = 1'b0;
      borrow  = 1'b0;
      if (inc && !dec) begin
         if (value_q == TOP) begin
            value_d = '0;
            carry   = 1'b1;
         end else begin
            value_d = value_q + ONE;
         end
      end else if (dec && !inc) begin
         // With wrap disabled the field floors at zero.
         if (value_q == '0) begin
            if (wrap_en) begin
               value_d = TOP;
               borrow  = 1'b1;
            end
         end else begin
            value_d = value_q - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/hms_timekeeper.sv
// Hours/minutes/seconds core: prescaler, up/down timing, adjust, countdown expiry.
module hms_timekeeper
   import hms_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int HOURS_MOD = 24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [1:0]         mode,
   input  logic               func,
   input  logic               plus,
   input  logic               minus,
   output logic [FIELD_W-1:0] hours,
   output logic [FIELD_W-1:0] mins,
   output logic [FIELD_W-1:0] secs,
   output logic               sec_tick,
   output logic               expired
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PSC_TOP = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] PSC_ONE = PW'(1);
   localparam logic [FIELD_W-1:0] F_ONE = FIELD_W'(1);

   logic [PW-1:0] psc_q;
   logic [PW-1:0] psc_d;
   logic          sec_tick_q;
   logic          expired_q;
   logic          expired_d;

   logic run;
   logic tick;
   logic up_tick;
   logic dn_tick;
   logic adj_plus;
   logic adj_minus;
   logic accepted;
   logic is_zero;
   logic one_left;
   logic wrap_en;

   logic s_inc, s_dec, s_carry, s_borrow;
   logic m_inc, m_dec, m_carry, m_borrow;
   logic h_inc, h_dec;
   logic unused_h_carry, unused_h_borrow;

   assign run     = (mode == MODE_RUN);
   assign tick    = run && enable && (psc_q == PSC_TOP);
   assign up_tick = tick && (func == FUNC_CLOCK);
   assign dn_tick = tick && (func == FUNC_COUNTDOWN);

   assign adj_plus  = !run && plus && !minus;
   assign adj_minus = !run && minus && !plus;
   assign accepted  = adj_plus || adj_minus;

   assign is_zero  = (hours == '0) && (mins == '0) && (secs == '0);
   assign one_left = (hours == '0) && (mins == '0) && (secs == F_ONE);
   assign wrap_en  = !(dn_tick && is_zero);

   // Timed carry/borrow chains only on ticks; adjust touches one field.
   assign s_inc = up_tick || (adj_plus && mode == MODE_SECS);
   assign s_dec = dn_tick || (adj_minus && mode == MODE_SECS);
   assign m_inc = (up_tick && s_carry) || (adj_plus && mode == MODE_MINS);
   assign m_dec = (dn_tick && s_borrow) || (adj_minus && mode == MODE_MINS);
   assign h_inc = (up_tick && m_carry) || (adj_plus && mode == MODE_HOURS);
   assign h_dec = (dn_tick && m_borrow) || (adj_minus && mode == MODE_HOURS);

   mod_counter #(.MOD(SEC_MOD)) u_secs (
      .clk     (clk),
      .reset   (reset),
      .inc     (s_inc),
      .dec     (s_dec),
      .wrap_en (wrap_en),
      .value   (secs),
      .carry   (s_carry),
      .borrow  (s_borrow)
   );

   mod_counter #(.MOD(MIN_MOD)) u_mins (
      .clk     (clk),
      .reset   (reset),
      .inc     (m_inc),
      .dec     (m_dec),
      .wrap_en (wrap_en),
      .value   (mins),
      .carry   (m_carry),
      .borrow  (m_borrow)
   );

   mod_counter #(.MOD(HOURS_MOD)) u_hours (
      .clk     (clk),
      .reset   (reset),
      .inc     (h_inc),
      .dec     (h_dec),
      .wrap_en (wrap_en),
      .value   (hours),
      .carry   (unused_h_carry),
      .borrow  (unused_h_borrow)
   );

   always_comb begin
      psc_d = psc_q;
      if (!run) begin
         psc_d = '0;
      end else if (enable) begin
         psc_d = tick ? '0 : psc_q + PSC_ONE;
      end
   end

   always_comb begin
      expired_d = expired_q;
      if (accepted || func == FUNC_CLOCK) begin
         expired_d = 1'b0;
      end else if (dn_tick && (is_zero || one_left)) begin
         expired_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         psc_q      <= '0;
         sec_tick_q <= 1'b0;
         expired_q  <= 1'b0;
      end else begin
         psc_q      <= psc_d;
         sec_tick_q <= tick;
         expired_q  <= expired_d;
      end
   end

   assign sec_tick = sec_tick_q;
   assign expired  = expired_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed scoreboard bench for hms_timekeeper at CLK_HZ=4 (24h and 12h copies).
module tb_hms_timekeeper;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       func = 1'b0;
   logic       plus = 1'b0;
   logic       minus = 1'b0;

   logic [5:0] hours, mins, secs;
   logic       sec_tick, expired;
   logic [5:0] hours12, mins12, secs12;
   logic       sec_tick12, expired12;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string tag;
      int    h;
      int    h12;
      int    m;
      int    s;
      bit    tk;
      bit    ex;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   hms_timekeeper #(.CLK_HZ(4), .HOURS_MOD(24)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .mode     (mode),
      .func     (func),
      .plus     (plus),
      .minus    (minus),
      .hours    (hours),
      .mins     (mins),
      .secs     (secs),
      .sec_tick (sec_tick),
      .expired  (expired)
   );

   hms_timekeeper #(.CLK_HZ(4), .HOURS_MOD(12)) dut12 (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .mode     (mode),
      .func     (func),
      .plus     (plus),
      .minus    (minus),
      .hours    (hours12),
      .mins     (mins12),
      .secs     (secs12),
      .sec_tick (sec_tick12),
      .expired  (expired12)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_tick(input string tag, input bit exp_tk);
      checks++;
      assert (sec_tick === exp_tk) else begin
         errors++;
         $error("FAIL %s sec_tick observed %0b expected %0b", tag, sec_tick, exp_tk);
      end
   endtask

   task automatic compare();
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert ({hours, mins, secs, sec_tick, expired} ===
              {6'(e.h), 6'(e.m), 6'(e.s), e.tk, e.ex}) else begin
         errors++;
         $error("FAIL %s observed %0d:%0d:%0d tick=%0b exp=%0b expected %0d:%0d:%0d tick=%0b exp=%0b",
                e.tag, hours, mins, secs, sec_tick, expired,
                e.h, e.m, e.s, e.tk, e.ex);
      end
      checks++;
      assert ({hours12, mins12, secs12} === {6'(e.h12), 6'(e.m), 6'(e.s)}) else begin
         errors++;
         $error("FAIL %s_h12 observed %0d:%0d:%0d expected %0d:%0d:%0d",
                e.tag, hours12, mins12, secs12, e.h12, e.m, e.s);
      end
   endtask

   task automatic step_chk(input int n, input string tag, input int h, input int h12,
                           input int m, input int s, input bit tk, input bit ex);
      exp_t e;
      e.tag = tag;
      e.h   = h;
      e.h12 = h12;
      e.m   = m;
      e.s   = s;
      e.tk  = tk;
      e.ex  = ex;
      sb.push_back(e);
      cyc(n);
      compare();
   endtask

   task automatic pulse(input bit p, input bit m, input int n);
      repeat (n) begin
         plus  = p;
         minus = m;
         cyc(1);
         plus  = 1'b0;
         minus = 1'b0;
         chk_tick("adj_notick", 1'b0);
         cyc(1);
      end
   endtask

   initial begin
      cyc(1);
      step_chk(1, "reset", 0, 0, 0, 0, 0, 0);
      reset  = 1'b0;
      enable = 1'b1;

      for (int i = 1; i <= 240; i++) begin
         cyc(1);
         chk_tick("upcount_tick", (i % 4) == 0);
      end
      step_chk(0, "upcount", 0, 0, 1, 0, 1, 0);

      mode  = 2'b01;
      minus = 1'b1;
      step_chk(1, "adj_sec_minus", 0, 0, 1, 59, 0, 0);
      minus = 1'b0;
      mode  = 2'b11;
      pulse(1'b1, 1'b0, 25);
      step_chk(0, "adj_hours25", 1, 1, 1, 59, 0, 0);
      plus  = 1'b1;
      minus = 1'b1;
      step_chk(1, "adj_both", 1, 1, 1, 59, 0, 0);
      plus  = 1'b0;
      minus = 1'b0;

      pulse(1'b0, 1'b1, 2);
      mode = 2'b10;
      pulse(1'b0, 1'b1, 2);
      step_chk(0, "preset_roll", 23, 11, 59, 59, 0, 0);
      mode = 2'b00;
      step_chk(3, "pre_roll", 23, 11, 59, 59, 0, 0);
      step_chk(1, "rollover", 0, 0, 0, 0, 1, 0);

      mode = 2'b01;
      pulse(1'b1, 1'b0, 2);
      func = 1'b1;
      mode = 2'b00;
      step_chk(4, "cd_one", 0, 0, 0, 1, 1, 0);
      step_chk(4, "cd_zero", 0, 0, 0, 0, 1, 1);
      step_chk(20, "cd_hold", 0, 0, 0, 0, 1, 1);
      mode = 2'b01;
      plus = 1'b1;
      step_chk(1, "cd_adj_clear", 0, 0, 0, 1, 0, 0);
      plus  = 1'b0;
      minus = 1'b1;
      step_chk(1, "adj_to_zero", 0, 0, 0, 0, 0, 0);
      minus = 1'b0;
      mode  = 2'b00;
      step_chk(4, "zero_tick", 0, 0, 0, 0, 1, 1);
      func = 1'b0;
      step_chk(1, "func_clear", 0, 0, 0, 0, 0, 0);

      mode = 2'b11;
      pulse(1'b1, 1'b0, 1);
      func = 1'b1;
      mode = 2'b00;
      step_chk(4, "borrow", 0, 0, 59, 59, 1, 0);

      step_chk(2, "pre_hold", 0, 0, 59, 59, 0, 0);
      enable = 1'b0;
      step_chk(10, "hold", 0, 0, 59, 59, 0, 0);
      enable = 1'b1;
      step_chk(1, "hold_resume", 0, 0, 59, 59, 0, 0);
      step_chk(1, "after_hold", 0, 0, 59, 58, 1, 0);

      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      func  = 1'b0;
      mode  = 2'b11;
      pulse(1'b1, 1'b0, 5);
      mode = 2'b10;
      pulse(1'b1, 1'b0, 6);
      mode = 2'b01;
      pulse(1'b1, 1'b0, 7);
      mode = 2'b00;
      step_chk(2, "pre_reset", 5, 5, 6, 7, 0, 0);
      reset = 1'b1;
      step_chk(1, "reset_mid", 0, 0, 0, 0, 0, 0);
      reset = 1'b0;

      mode = 2'b11;
      pulse(1'b1, 1'b0, 3);
      mode  = 2'b01;
      plus  = 1'b1;
      reset = 1'b1;
      step_chk(1, "reset_adj", 0, 0, 0, 0, 0, 0);
      plus  = 1'b0;
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
